// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Add, slbi, xor and and finish in one cycle. Shifts and rotates move one bit per cycle.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    input  logic             cin,
    input  logic [2:0]       aluControl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int HALF  = WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shreg;
    logic [AMT_W-1:0]   cnt;
    logic [1:0]         shift_op;

    logic               accept;
    logic [WIDTH-1:0]   a_eff;
    logic [WIDTH-1:0]   b_eff;
    logic [AMT_W-1:0]   amt;
    logic               is_shift;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   op_result;
    logic               op_cout;
    logic               op_ofl;
    logic [WIDTH-1:0]   shreg_next;

    // Operand inversion applies to every op, including shifts.
    assign a_eff    = invA ? ~A : A;
    assign b_eff    = invB ? ~B : B;
    assign amt      = b_eff[AMT_W-1:0];
    assign is_shift = ~aluControl[2];

    assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    assign add_sum = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

    // Single-cycle result and flags for whatever op is presented at the input.
    always_comb begin
        op_result = a_eff;
        op_cout   = 1'b0;
        op_ofl    = 1'b0;
        case (aluControl)
            3'b100: begin
                op_result = add_sum[WIDTH-1:0];
                op_cout   = add_sum[WIDTH];
                op_ofl    = sign ? ((a_eff[WIDTH-1] == b_eff[WIDTH-1]) &&
                                    (add_sum[WIDTH-1] != a_eff[WIDTH-1]))
                                 : add_sum[WIDTH];
            end
            3'b101:  op_result = {a_eff[HALF-1:0], b_eff[HALF-1:0]};
            3'b110:  op_result = a_eff ^ b_eff;
            3'b111:  op_result = a_eff & b_eff;
            default: op_result = a_eff;
        endcase
    end

    // One-bit step of the shift register: rotates wrap, logical shifts zero-fill.
    always_comb begin
        shreg_next = shreg;
        case (shift_op)
            2'b00:   shreg_next = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
            2'b01:   shreg_next = {shreg[WIDTH-2:0], 1'b0};
            2'b10:   shreg_next = {shreg[0], shreg[WIDTH-1:1]};
            default: shreg_next = {1'b0, shreg[WIDTH-1:1]};
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything, including a pending accept.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = (is_shift && (amt != '0)) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (cnt == AMT_W'(1)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state_next = (is_shift && (amt != '0)) ? SHIFT : DONE;
                    end else if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: capture on accept, step the shifter, and hold outputs otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            cout     <= 1'b0;
            ofl      <= 1'b0;
            zero     <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
            shift_op <= 2'b00;
        end else if (!flush) begin
            if (accept) begin
                if (is_shift && (amt != '0)) begin
                    shreg    <= a_eff;
                    cnt      <= amt;
                    shift_op <= aluControl[1:0];
                end else begin
                    result <= op_result;
                    cout   <= op_cout;
                    ofl    <= op_ofl;
                    zero   <= (op_result == '0);
                end
            end else if (state == SHIFT) begin
                shreg <= shreg_next;
                cnt   <= cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    result <= shreg_next;
                    cout   <= 1'b0;
                    ofl    <= 1'b0;
                    zero   <= (shreg_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector bench for alu_exec with hand-computed expectations.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        invA;
    logic        invB;
    logic        sign;
    logic        cin;
    logic [2:0]  aluControl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ofl;
    logic        zero;

    int checks = 0;
    int fails  = 0;

    alu_exec #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .invA       (invA),
        .invB       (invB),
        .sign       (sign),
        .cin        (cin),
        .aluControl (aluControl),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .cout       (cout),
        .ofl        (ofl),
        .zero       (zero)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic ia, input logic ib, input logic s,
                                 input logic c, input logic [2:0] ctl);
        in_valid   = v;
        A          = a;
        B          = b;
        invA       = ia;
        invB       = ib;
        sign       = s;
        cin        = c;
        aluControl = ctl;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        #3;
        checkOutput("reset_out_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("reset_result", result, 16'h0000);
        checkOutput("reset_flags", {13'b0, cout, ofl, zero}, 16'd0);
        checkOutput("reset_in_ready", {15'b0, in_ready}, 16'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Signed add overflow.
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100);
        tick();
        in_valid = 1'b0;
        checkOutput("addovf_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("addovf_result", result, 16'h8000);
        checkOutput("addovf_flags", {13'b0, cout, ofl, zero}, 16'b010);
        tick();
        checkOutput("addovf_valid_drop", {15'b0, out_valid}, 16'd0);

        // Subtraction 5-3 then 5-5 back-to-back.
        applyStimulus(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100);
        tick();
        checkOutput("sub_result", result, 16'h0002);
        checkOutput("sub_flags", {13'b0, cout, ofl, zero}, 16'b100);
        checkOutput("sub_in_ready", {15'b0, in_ready}, 16'd1);
        applyStimulus(1'b1, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100);
        tick();
        in_valid = 1'b0;
        checkOutput("subz_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("subz_result", result, 16'h0000);
        checkOutput("subz_flags", {13'b0, cout, ofl, zero}, 16'b101);
        tick();

        // Rotate left by 4: four cycles in SHIFT with input blocked.
        applyStimulus(1'b1, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("rol_busy_valid", {15'b0, out_valid}, 16'd0);
            checkOutput("rol_busy_ready", {15'b0, in_ready}, 16'd0);
            tick();
        end
        checkOutput("rol_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("rol_result", result, 16'h0018);
        tick();

        // Logical shift right by 15.
        applyStimulus(1'b1, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            checkOutput("srl_busy_valid", {15'b0, out_valid}, 16'd0);
            tick();
        end
        checkOutput("srl_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("srl_result", result, 16'h0001);
        checkOutput("srl_zero", {15'b0, zero}, 16'd0);
        tick();

        // Rotate with amount 0 (bit 4 ignored) completes in one cycle.
        applyStimulus(1'b1, 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        in_valid = 1'b0;
        checkOutput("rol0_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("rol0_result", result, 16'h1234);
        tick();

        // AND with inverted B operand.
        applyStimulus(1'b1, 16'hF0F0, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111);
        tick();
        in_valid = 1'b0;
        checkOutput("and_invb_result", result, 16'hF000);
        tick();

        // Backpressure on slbi while an xor waits at the input.
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h00AB, 16'h00CD, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101);
        tick();
        applyStimulus(1'b1, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_valid", {15'b0, out_valid}, 16'd1);
            checkOutput("bp_result", result, 16'hABCD);
            checkOutput("bp_in_ready", {15'b0, in_ready}, 16'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {15'b0, in_ready}, 16'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("xor_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("xor_result", result, 16'hF0F0);
        tick();
        checkOutput("xor_drop", {15'b0, out_valid}, 16'd0);

        // Flush in the middle of an sll by 10.
        applyStimulus(1'b1, 16'h0001, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("flush_in_ready", {15'b0, in_ready}, 16'd1);
        checkOutput("flush_result_kept", result, 16'hF0F0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("flush_stays_idle", {15'b0, out_valid}, 16'd0);
        end

        // Flush wins over a simultaneous accept.
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        flush = 1'b1;
        #1;
        checkOutput("flush_blocks_ready", {15'b0, in_ready}, 16'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_no_accept", {15'b0, out_valid}, 16'd0);

        // Asynchronous reset during a shift.
        applyStimulus(1'b1, 16'h0001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("arst_result", result, 16'h0000);
        checkOutput("arst_in_ready", {15'b0, in_ready}, 16'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("arst_no_output", {15'b0, out_valid}, 16'd0);
        end
        applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        tick();
        in_valid = 1'b0;
        checkOutput("post_rst_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("post_rst_result", result, 16'h0003);
        checkOutput("post_rst_flags", {13'b0, cout, ofl, zero}, 16'b000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
